// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output capture path.
package fft_pkg;

  localparam int FFT_N = 1024;
  localparam int FFT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_capture_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port (1-cycle latency).
module fft_capture_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_frame_capture.sv
// Arms on request, skips SKIP enabled samples, captures one N-point frame and streams it out.
// Define CAPTURE_MAG_EN to add the rd_mag L1-magnitude output.
module fft_frame_capture
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int W    = FFT_W,
  parameter int SKIP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [W-1:0]         xb_re,
  input  logic [W-1:0]         xb_im,
  input  logic                 arm,
  output logic                 busy,
  output logic                 frame_ready,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [$clog2(N)-1:0] rd_idx,
  output logic [W-1:0]         rd_re,
  output logic [W-1:0]         rd_im,
  output logic                 rd_last
`ifdef CAPTURE_MAG_EN
  ,
  output logic [W:0]           rd_mag
`endif
);

  localparam int              AW       = $clog2(N);
  localparam int              DW       = 2 * W;
  localparam logic [16:0]     SKIP_C   = 17'(SKIP);
  localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);

  cap_state_e    state_q, state_d;
  logic [16:0]   skip_cnt_q, skip_cnt_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW:0]   fetch_addr_q, fetch_addr_d;
  logic          ram_vld_q, ram_vld_d;
  logic [AW-1:0] ram_idx_q, ram_idx_d;
  logic          skid_vld_q, skid_vld_d;
  logic [AW-1:0] skid_idx_q, skid_idx_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [W-1:0]  rd_re_q, rd_re_d;
  logic [W-1:0]  rd_im_q, rd_im_d;
  logic          rd_last_q, rd_last_d;
  logic          busy_q, busy_d;
  logic          frame_ready_q, frame_ready_d;

  logic          wr_en_s, rd_en_s, fetch_en_s;
  logic          capture_done_s, readout_done_s, pop_s, out_free_s;
  logic [1:0]    occ_s;
  logic [DW-1:0] ram_rdata_s;

  fft_capture_ram #(
    .DEPTH (N),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_cnt_q),
    .wdata ({xb_re, xb_im}),
    .re    (rd_en_s),
    .raddr (fetch_addr_q[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign pop_s          = rd_valid_q & rd_ready;
  assign out_free_s     = ~rd_valid_q | pop_s;
  assign readout_done_s = (state_q == ST_READOUT) & pop_s & rd_last_q;
  // Word 0 is fetched alongside the final write so rd_valid rises one cycle into READOUT.
  assign fetch_en_s     = (state_q == ST_READOUT) | capture_done_s;
  assign occ_s          = 2'(rd_valid_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop_s);
  assign rd_en_s        = fetch_en_s & ~fetch_addr_q[AW] & (occ_s < 2'd2);

  // Capture FSM: arm, latency skip, frame write, readout hand-off
  always_comb begin
    state_d        = state_q;
    skip_cnt_d     = skip_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    wr_en_s        = 1'b0;
    capture_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          skip_cnt_d = 17'd0;
          wr_cnt_d   = '0;
          state_d    = (SKIP_C == 17'd0) ? ST_CAPTURE : ST_SKIP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (enable) begin
          skip_cnt_d = skip_cnt_q + 17'd1;
          if ((skip_cnt_q + 17'd1) == SKIP_C) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SKIP;
          end
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_CAPTURE: begin
        if (enable) begin
          wr_en_s  = 1'b1;
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (wr_cnt_q == LAST_IDX) begin
            capture_done_s = 1'b1;
            state_d        = ST_READOUT;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_READOUT: begin
        if (readout_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d        = (state_d == ST_SKIP) | (state_d == ST_CAPTURE);
    frame_ready_d = (state_d == ST_READOUT);
  end

  // Read pipeline: RAM output feeds the output word, overflow parks in the skid entry
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    ram_vld_d    = rd_en_s;
    ram_idx_d    = fetch_addr_q[AW-1:0];
    skid_vld_d   = skid_vld_q;
    skid_idx_d   = skid_idx_q;
    skid_data_d  = skid_data_q;
    rd_valid_d   = rd_valid_q;
    rd_idx_d     = rd_idx_q;
    rd_re_d      = rd_re_q;
    rd_im_d      = rd_im_q;
    rd_last_d    = rd_last_q;
    if (readout_done_s) begin
      fetch_addr_d = '0;
      ram_vld_d    = 1'b0;
      skid_vld_d   = 1'b0;
      rd_valid_d   = 1'b0;
      rd_last_d    = 1'b0;
    end else begin
      if (rd_en_s) begin
        fetch_addr_d = fetch_addr_q + (AW + 1)'(1);
      end else begin
        fetch_addr_d = fetch_addr_q;
      end
      if (out_free_s) begin
        if (skid_vld_q) begin
          rd_valid_d         = 1'b1;
          rd_idx_d           = skid_idx_q;
          {rd_re_d, rd_im_d} = skid_data_q;
          rd_last_d          = (skid_idx_q == LAST_IDX);
          skid_vld_d         = ram_vld_q;
          skid_idx_d         = ram_idx_q;
          skid_data_d        = ram_rdata_s;
        end else if (ram_vld_q) begin
          rd_valid_d         = 1'b1;
          rd_idx_d           = ram_idx_q;
          {rd_re_d, rd_im_d} = ram_rdata_s;
          rd_last_d          = (ram_idx_q == LAST_IDX);
        end else begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end else if (ram_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_idx_d  = ram_idx_q;
        skid_data_d = ram_rdata_s;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      skip_cnt_q    <= 17'd0;
      wr_cnt_q      <= '0;
      fetch_addr_q  <= '0;
      ram_vld_q     <= 1'b0;
      ram_idx_q     <= '0;
      skid_vld_q    <= 1'b0;
      skid_idx_q    <= '0;
      skid_data_q   <= '0;
      rd_valid_q    <= 1'b0;
      rd_idx_q      <= '0;
      rd_re_q       <= '0;
      rd_im_q       <= '0;
      rd_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      fetch_addr_q  <= fetch_addr_d;
      ram_vld_q     <= ram_vld_d;
      ram_idx_q     <= ram_idx_d;
      skid_vld_q    <= skid_vld_d;
      skid_idx_q    <= skid_idx_d;
      skid_data_q   <= skid_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_idx_q      <= rd_idx_d;
      rd_re_q       <= rd_re_d;
      rd_im_q       <= rd_im_d;
      rd_last_q     <= rd_last_d;
      busy_q        <= busy_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign busy        = busy_q;
  assign frame_ready = frame_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_idx      = rd_idx_q;
  assign rd_re       = rd_re_q;
  assign rd_im       = rd_im_q;
  assign rd_last     = rd_last_q;

`ifdef CAPTURE_MAG_EN
  // Widening before negation makes the most-negative input map to 2^(W-1).
  function automatic logic [W:0] abs_ext(input logic [W-1:0] x);
    logic [W:0] ext;
    ext = {x[W-1], x};
    if (x[W-1]) begin
      return (~ext) + (W + 1)'(1);
    end else begin
      return ext;
    end
  endfunction

  assign rd_mag = abs_ext(rd_re_q) + abs_ext(rd_im_q);
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// Self-checking bench: two captures (SKIP=0 and SKIP=5) share stimulus and are checked against a frame-level model.
module tb_fft_frame_capture;

  localparam int N  = 1024;
  localparam int W  = 16;
  localparam int AW = $clog2(N);
  localparam int P_IDLE = 0, P_SKIP = 1, P_CAP = 2, P_READ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic arm = 1'b0;
  logic rd_ready = 1'b0;
  logic [W-1:0] xb_re = '0;
  logic [W-1:0] xb_im = '0;

  logic          o_busy [2];
  logic          o_fr   [2];
  logic          o_vld  [2];
  logic          o_last [2];
  logic [AW-1:0] o_idx  [2];
  logic [W-1:0]  o_re   [2];
  logic [W-1:0]  o_im   [2];
`ifdef CAPTURE_MAG_EN
  logic [W:0]    o_mag  [2];
  logic [W:0]    g_mag  [2][N];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int           ph [2];
  int           cnt [2];
  int           rdk [2];
  logic         first [2];
  logic [W-1:0] m_re [2][N];
  logic [W-1:0] m_im [2][N];
  // words actually handed over
  logic [W-1:0] g_re [2][N];
  logic [W-1:0] g_im [2][N];
  int           got_n [2];
  int           last_n [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft_frame_capture #(.N(N), .W(W), .SKIP(g * 5)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .xb_re       (xb_re),
      .xb_im       (xb_im),
      .arm         (arm),
      .busy        (o_busy[g]),
      .frame_ready (o_fr[g]),
      .rd_valid    (o_vld[g]),
      .rd_ready    (rd_ready),
      .rd_idx      (o_idx[g]),
      .rd_re       (o_re[g]),
      .rd_im       (o_im[g]),
      .rd_last     (o_last[g])
`ifdef CAPTURE_MAG_EN
      ,
      .rd_mag      (o_mag[g])
`endif
    );
  end

  always #5 clk = ~clk;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Frame-level model: count enabled samples after arm, keep frame, replay it in bin order
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] <= P_IDLE; cnt[d] <= 0; rdk[d] <= 0; first[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (o_vld[d] && rd_ready) begin
          g_re[d][o_idx[d]] <= o_re[d];
          g_im[d][o_idx[d]] <= o_im[d];
`ifdef CAPTURE_MAG_EN
          g_mag[d][o_idx[d]] <= o_mag[d];
`endif
          got_n[d] <= got_n[d] + 1;
          if (o_last[d]) last_n[d] <= last_n[d] + 1;
        end
        case (ph[d])
          P_IDLE: if (arm) begin
            ph[d] <= (d == 0) ? P_CAP : P_SKIP;
            cnt[d] <= 0; got_n[d] <= 0; last_n[d] <= 0;
          end
          P_SKIP: if (enable) begin
            if (cnt[d] + 1 == d * 5) begin ph[d] <= P_CAP; cnt[d] <= 0; end
            else cnt[d] <= cnt[d] + 1;
          end
          P_CAP: if (enable) begin
            m_re[d][cnt[d]] <= xb_re;
            m_im[d][cnt[d]] <= xb_im;
            if (cnt[d] == N - 1) begin
              ph[d] <= P_READ; first[d] <= 1'b1; rdk[d] <= 0; cnt[d] <= 0;
            end else cnt[d] <= cnt[d] + 1;
          end
          P_READ: begin
            if (first[d]) first[d] <= 1'b0;
            else if (rd_ready) begin
              if (rdk[d] == N - 1) ph[d] <= P_IDLE;
              rdk[d] <= rdk[d] + 1;
            end
          end
          default: ph[d] <= P_IDLE;
        endcase
      end
    end
  end

  task automatic check_cycle(input int d);
    logic eb, ef, ev, el, bad;
    logic [W-1:0] er, ei;
    eb = (ph[d] == P_SKIP) || (ph[d] == P_CAP);
    ef = (ph[d] == P_READ);
    ev = ef && !first[d];
    er = '0; ei = '0; el = 1'b0;
    bad = (o_busy[d] !== eb) || (o_fr[d] !== ef) || (o_vld[d] !== ev);
    if (ev) begin
      er = m_re[d][rdk[d]];
      ei = m_im[d][rdk[d]];
      el = (rdk[d] == N - 1);
      bad = bad || (o_idx[d] !== AW'(rdk[d])) || (o_re[d] !== er) || (o_im[d] !== ei) || (o_last[d] !== el);
`ifdef CAPTURE_MAG_EN
      bad = bad || (o_mag[d] !== (W + 1)'(iabs(int'($signed(er))) + iabs(int'($signed(ei)))));
`endif
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      if (n_fail < 20)
        $display("FAIL cycle dut%0d t=%0t: got busy=%0b fr=%0b vld=%0b idx=%0d re=%0h im=%0h last=%0b, expected busy=%0b fr=%0b vld=%0b idx=%0d re=%0h im=%0h last=%0b",
                 d, $time, o_busy[d], o_fr[d], o_vld[d], o_idx[d], o_re[d], o_im[d], o_last[d],
                 eb, ef, ev, rdk[d], er, ei, el);
    end
  endtask

  // Per-cycle comparison, just after each active edge
  always @(posedge clk) begin
    #1;
    check_cycle(0);
    check_cycle(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_arm();
    @(negedge clk); arm = 1'b1; enable = 1'b0;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic drive_ramp(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      enable = 1'b1; xb_re = W'(base + i); xb_im = W'(-(base + i));
      @(negedge clk);
    end
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (!o_busy[0] && !o_busy[1] && !o_fr[0] && !o_fr[1]) begin ok = 1'b1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic stall_at(input int idx, input int len);
    bit seen = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (o_vld[0] && int'(o_idx[0]) == idx) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("stall_seen", int'(seen), 1);
    if (seen) begin
      rd_ready = 1'b0;
      repeat (len) @(negedge clk);
      rd_ready = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"}, int'(o_busy[d]), 0);
      chk({tag, "_fr"},   int'(o_fr[d]), 0);
      chk({tag, "_vld"},  int'(o_vld[d]), 0);
      chk({tag, "_last"}, int'(o_last[d]), 0);
      chk({tag, "_idx"},  int'(o_idx[d]), 0);
      chk({tag, "_re"},   int'(o_re[d]), 0);
      chk({tag, "_im"},   int'(o_im[d]), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);

    // basic frame and latency skip
    do_arm();
    drive_ramp(1030, 0);
    wait_idle("basic_idle");
    chk("basic_count", got_n[0], 1024);
    chk("basic_last_once", last_n[0], 1);
    chk("basic_re0", int'(g_re[0][0]), 0);
    chk("basic_re1023", int'(g_re[0][1023]), 1023);
    chk("basic_im1023", int'($signed(g_im[0][1023])), -1023);
    chk("skip_count", got_n[1], 1024);
    chk("skip_first", int'(g_re[1][0]), 5);
    chk("skip_bin1023", int'(g_re[1][1023]), 1028);

    // enable holes plus back-pressure at idx 10 and 1023
    do_arm();
    fork
      begin
        for (int j = 0; j < 2100; j++) begin
          enable = (j % 2 == 0); xb_re = W'(2000 + j); xb_im = W'(-(2000 + j));
          @(negedge clk);
        end
        enable = 1'b0;
      end
      begin
        stall_at(10, 3);
        stall_at(1023, 2);
      end
    join
    wait_idle("holes_idle");
    chk("holes_count", got_n[0], 1024);
    chk("holes_last_once", last_n[0], 1);
    chk("holes_re10", int'(g_re[0][10]), 2020);
    chk("holes_re1023", int'(g_re[0][1023]), 4046);
    chk("holes_skip_first", int'(g_re[1][0]), 2010);
    chk("holes_skip_1023", int'(g_re[1][1023]), 4056);

    // ignored arm in CAPTURE, then reset mid-capture
    do_arm();
    for (int i = 0; i < 700; i++) begin
      arm = (i == 500); enable = 1'b1; xb_re = W'(3000 + i); xb_im = W'(-(3000 + i));
      @(negedge clk);
    end
    arm = 1'b0; enable = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b1;
    @(negedge clk);
    do_arm();
    drive_ramp(1030, 5000);
    wait_idle("fresh_idle");
    chk("fresh_count", got_n[0], 1024);
    chk("fresh_re0", int'(g_re[0][0]), 5000);
    chk("fresh_re1023", int'(g_re[0][1023]), 6023);
    chk("fresh_skip_first", int'(g_re[1][0]), 5005);

`ifdef CAPTURE_MAG_EN
    do_arm();
    for (int i = 0; i < 1030; i++) begin
      enable = 1'b1;
      if (i == 0) begin xb_re = 16'h8000; xb_im = 16'd3; end
      else if (i == 1) begin xb_re = 16'd100; xb_im = W'(-50); end
      else begin xb_re = W'(i); xb_im = W'(-i); end
      @(negedge clk);
    end
    enable = 1'b0;
    wait_idle("mag_idle");
    chk("mag_min_neg", int'(g_mag[0][0]), 32771);
    chk("mag_mixed", int'(g_mag[0][1]), 150);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
